vga_frame_monitor: RTL and testbench

Passive VGA sink that observes the video stream produced by the display path (`hsync`, `vsync`, 4-bit `red`/`green`/`blue`) and does three things:
- recovers pixel coordinates from the syncs alone;
- checks 640x480 timing;
- reports per-frame statistics on foreground (non-background) pixels: bounding box, pixel count and checksum.

It sits beside the display block for on-board self-test and serves as the reusable checker in the display testbenches.

---
 rtl/vga_frame_monitor.sv | 112 +++++++++++
 tb/tb_vga_frame_monitor.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_monitor.sv
// vga_frame_monitor: passive VGA sink recovering coordinates from syncs, checking timing and reporting per-frame foreground stats.
// Optional VGA_MON_CHECKSUM_EN builds the checksum accumulator; otherwise checksum is tied to 0.
module vga_frame_monitor #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP = 33,
  parameter logic [11:0] BG_COLOR = 12'h000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        px_tick,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic        locked,
  output logic        frame_valid,
  output logic [9:0]  min_x,
  output logic [9:0]  max_x,
  output logic [9:0]  min_y,
  output logic [9:0]  max_y,
  output logic [18:0] pix_count,
  output logic [15:0] checksum,
  output logic        sync_err
);
  localparam logic [9:0] HA0 = 10'(H_SYNC + H_BP);
  localparam logic [9:0] HA1 = 10'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [9:0] VA0 = 10'(V_SYNC + V_BP);
  localparam logic [9:0] VA1 = 10'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [9:0] HEND = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VEND = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP);
  localparam logic [9:0] HSW = 10'(H_SYNC);
  typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;
  state_t state, state_n;
  logic hs_q, vs_q, lo_ok, frame_err;
  logic [9:0] h_cnt, v_cnt, lo_cnt, x, y;
  logic [9:0] a_min_x, a_max_x, a_min_y, a_max_y;
  logic [18:0] a_cnt;
  logic [11:0] color;
  logic h_fall, h_rise, v_fall, bad, fg, latch;
  always_comb begin
    color = {red, green, blue};
    h_fall = px_tick & hs_q & ~hsync;
    h_rise = px_tick & ~hs_q & hsync;
    v_fall = px_tick & vs_q & ~vsync;
    // a stalled counter means a missing sync edge, so saturation is itself a violation
    bad = px_tick & ((h_fall & ((h_cnt != HEND) | ~lo_ok)) | (v_fall & (v_cnt != VEND)) |
                     (h_cnt == 10'h3ff) | (v_cnt == 10'h3ff));
    x = h_cnt - HA0;
    y = v_cnt - VA0;
    fg = px_tick & (h_cnt >= HA0) & (h_cnt < HA1) & (v_cnt >= VA0) & (v_cnt < VA1) & (color != BG_COLOR);
    state_n = (state == SEARCH) ? (v_fall ? MEASURE : SEARCH) :
              (state == MEASURE) ? (v_fall ? ((frame_err | bad) ? SEARCH : LOCKED) : MEASURE) :
              (bad ? SEARCH : LOCKED);
    latch = (state == LOCKED) & v_fall & ~bad;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= SEARCH;
      {hs_q, vs_q} <= 2'b11;
      {lo_ok, frame_err, locked, frame_valid, sync_err} <= '0;
      {h_cnt, v_cnt, lo_cnt} <= '0;
      {a_min_x, a_max_x, a_min_y, a_max_y, a_cnt} <= '0;
      {min_x, max_x, min_y, max_y, pix_count} <= '0;
    end else begin
      state <= state_n;
      frame_valid <= latch;
      sync_err <= bad & (state == LOCKED);
      locked <= (state_n == LOCKED) & (locked | latch);
      if (px_tick) begin
        hs_q <= hsync;
        vs_q <= vsync;
        h_cnt <= h_fall ? '0 : h_cnt + 10'(h_cnt != 10'h3ff);
        v_cnt <= v_fall ? '0 : h_fall ? v_cnt + 10'(v_cnt != 10'h3ff) : v_cnt;
        if (!hsync) lo_cnt <= h_fall ? 10'd1 : lo_cnt + 10'(lo_cnt != 10'h3ff);
        if (h_rise) lo_ok <= (lo_cnt == HSW);
        frame_err <= v_fall ? 1'b0 : frame_err | bad;
      end
      if (v_fall) begin
        {a_min_x, a_min_y} <= '1;
        {a_max_x, a_max_y, a_cnt} <= '0;
      end else if (fg) begin
        a_min_x <= (x < a_min_x) ? x : a_min_x;
        a_max_x <= (x > a_max_x) ? x : a_max_x;
        a_min_y <= (y < a_min_y) ? y : a_min_y;
        a_max_y <= (y > a_max_y) ? y : a_max_y;
        a_cnt <= a_cnt + 19'd1;
      end
      if (latch) {min_x, max_x, min_y, max_y, pix_count} <= {a_min_x, a_max_x, a_min_y, a_max_y, a_cnt};
    end
  end
`ifdef VGA_MON_CHECKSUM_EN
  logic [15:0] a_sum;
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sum <= '0;
      checksum <= '0;
    end else begin
      a_sum <= v_fall ? '0 : fg ? a_sum + 16'(color) : a_sum;
      if (latch) checksum <= a_sum;
    end
  end
`else
  assign checksum = '0;
`endif
endmodule

// File: tb/tb_vga_frame_monitor.sv
// tb_vga_frame_monitor: randomized small-geometry VGA stream with frame-level scoreboard of stats and sync errors.
module tb_vga_frame_monitor;
  localparam int HA = 16, HF = 3, HS = 4, HB = 5, VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int HT = HA + HF + HS + HB, VT = VA + VF + VS + VB, MID = HT / 2;
  logic clk = 0, reset, px_tick, hsync, vsync;
  logic [3:0] red, green, blue;
  logic locked, frame_valid, sync_err;
  logic [9:0] min_x, max_x, min_y, max_y;
  logic [18:0] pix_count;
  logic [15:0] checksum;
  typedef struct {bit err; int mnx, mxx, mny, mxy, cnt, sum;} ev_t;
  ev_t q[$];
  ev_t held, e;
  ev_t zero = '{0, 0, 0, 0, 0, 0, 0};
  logic [11:0] img [VA][HA];
  int total = 0, bad = 0, wait_n = 1;
  bit locked_m = 0;

  vga_frame_monitor #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
                      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .BG_COLOR(12'h000)) dut (
    .clk(clk), .reset(reset), .px_tick(px_tick), .hsync(hsync), .vsync(vsync),
    .red(red), .green(green), .blue(blue), .locked(locked), .frame_valid(frame_valid),
    .min_x(min_x), .max_x(max_x), .min_y(min_y), .max_y(max_y),
    .pix_count(pix_count), .checksum(checksum), .sync_err(sync_err));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic ev_t ref_stats();
    ev_t r = '{0, 1023, 0, 1023, 0, 0, 0};
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        if (img[y][x] != 12'h000) begin
          if (x < r.mnx) r.mnx = x;
          if (x > r.mxx) r.mxx = x;
          if (y < r.mny) r.mny = y;
          if (y > r.mxy) r.mxy = y;
          r.cnt++;
          r.sum += int'(img[y][x]);
        end
`ifdef VGA_MON_CHECKSUM_EN
    r.sum = r.sum % 65536;
`else
    r.sum = 0;
`endif
    return r;
  endfunction

  task automatic set_img(input int mode);
    for (int y = 0; y < VA; y++)
      for (int x = 0; x < HA; x++)
        case (mode)
          1: img[y][x] = (x >= 3 && x < 9 && y >= 2 && y < 6) ? 12'hFFF : 12'h000;
          2: img[y][x] = (x == HA - 1 && y == VA - 1) ? 12'hF00 : 12'h000;
          3: img[y][x] = ($urandom_range(3) == 0) ? 12'($urandom_range(4095, 1)) : 12'h000;
          default: img[y][x] = 12'h000;
        endcase
  endtask

  task automatic tick(input logic hs, input logic vs, input logic [11:0] c);
    if ($urandom_range(2) == 0) begin
      px_tick = 0;
      hsync = 1'($urandom);
      vsync = 1'($urandom);
      {red, green, blue} = 12'($urandom);
      @(posedge clk); #1;
    end
    px_tick = 1;
    hsync = hs;
    vsync = vs;
    {red, green, blue} = c;
    @(posedge clk); #1;
  endtask

  task automatic check_zero(input string nm);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_fv"}, frame_valid, 0);
    chk({nm, "_serr"}, sync_err, 0);
    chk({nm, "_min_x"}, min_x, 0);
    chk({nm, "_max_x"}, max_x, 0);
    chk({nm, "_min_y"}, min_y, 0);
    chk({nm, "_max_y"}, max_y, 0);
    chk({nm, "_count"}, pix_count, 0);
    chk({nm, "_sum"}, checksum, 0);
  endtask

  task automatic do_reset();
    reset = 1;
    px_tick = 0;
    @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    reset = 0;
    locked_m = 0;
    held = zero;
    wait_n = 2;
    @(posedge clk); #1;
  endtask

  task automatic run_line(input int l, input int len, input int rl);
    int x, y;
    for (int p = 0; p < len; p++) begin
      if (l == rl && p == 12) do_reset();
      x = p - 1 - (HS + HB);
      y = l - (VS + VB);
      tick(p >= HS, !((l == 0 && p >= MID) || (l > 0 && l < VS) || (l == VS && p < MID)),
           (x >= 0 && x < HA && y >= 0 && y < VA) ? img[y][x] : 12'($urandom));
    end
  endtask

  task automatic push_err();
    ev_t ev = held;
    ev.err = 1;
    q.push_back(ev);
  endtask

  task automatic run_frame(input int mode, input int nl, input int sl, input int rl);
    ev_t r;
    set_img(mode);
    r = ref_stats();
    if (sl >= 0) begin
      if (locked_m) push_err();
      locked_m = 0;
      wait_n = 2;
    end
    for (int l = 0; l < nl; l++) run_line(l, (l == sl) ? HT - 1 : HT, rl);
    if (nl != VT) begin
      if (locked_m) push_err();
      locked_m = 0;
      wait_n = 2;
    end else if (wait_n > 0) wait_n--;
    else begin
      q.push_back(r);
      held = r;
      locked_m = 1;
    end
  endtask

  always @(negedge clk)
    if (!reset && (frame_valid || sync_err)) begin
      if (q.size() == 0) chk("unexpected_pulse", {frame_valid, sync_err}, 0);
      else begin
        e = q.pop_front();
        chk("frame_valid", frame_valid, !e.err);
        chk("sync_err", sync_err, e.err);
        chk("locked", locked, !e.err);
        chk("min_x", min_x, e.mnx);
        chk("max_x", max_x, e.mxx);
        chk("min_y", min_y, e.mny);
        chk("max_y", max_y, e.mxy);
        chk("pix_count", pix_count, e.cnt);
        chk("checksum", checksum, e.sum);
      end
    end

  initial begin
    reset = 1;
    px_tick = 0;
    hsync = 1;
    vsync = 1;
    {red, green, blue} = '0;
    held = zero;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero("init");
    reset = 0;
    @(posedge clk); #1;
    run_frame(1, VT, -1, -1);
    run_frame(1, VT, -1, -1);
    run_frame(1, VT, -1, -1);
    run_frame(0, VT, -1, -1);
    run_frame(0, VT, -1, -1);
    run_frame(3, VT, 8, -1);
    run_frame(3, VT, -1, -1);
    run_frame(3, VT, -1, -1);
    run_frame(2, VT, -1, -1);
    run_frame(3, VT - 1, -1, -1);
    run_frame(3, VT, -1, -1);
    run_frame(3, VT, -1, -1);
    run_frame(3, VT, -1, -1);
    run_frame(1, VT, -1, 7);
    run_frame(3, VT, -1, -1);
    run_frame(2, VT, -1, -1);
    run_frame(3, VT, -1, -1);
    run_line(0, HT, -1);
    px_tick = 0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", q.size(), 0);
    chk("final_locked", locked, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
